// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and requester indices for dmem_arbiter.
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
// The requester not granted last wins a tie; a lone request always wins.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win
);
    assign o_win[0] = i_req[0] && (!i_req[1] || i_last == REQ_LDR);
    assign o_win[1] = i_req[1] && (!i_req[0] || i_last == REQ_CPU);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates a CPU port and a loader/debug port onto one data memory
// with fixed latency (grant one cycle after sampling, done the cycle after that).
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            r_state;
    state_t            w_next;
    logic              r_last;
    logic              r_win;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        w_win;
    logic              w_sel1;
    logic              w_start;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rd;

    rr_arb2 u_arb (
        .i_req  ({req1, req0}),
        .i_last (r_last),
        .o_win  (w_win)
    );

    assign w_sel1     = w_win[1] && !w_win[0];
    assign w_start    = r_state == IDLE && (req0 || req1);
    assign w_in_range = 64'(r_addr) < 64'(MEM_DEPTH);
    assign w_rd       = w_in_range ? mem_rdata : '0;
    assign mem_raddr  = r_addr;
    assign mem_waddr  = r_addr;
    assign mem_wdata  = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // gnt/done/err/mem_we decode from state only, so reset clears them at once
    always_comb begin
        w_next = r_state;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        done0  = 1'b0;
        done1  = 1'b0;
        err    = 1'b0;
        mem_we = 1'b0;
        case (r_state)
            IDLE:    w_next = (req0 || req1) ? ACCESS : IDLE;
            ACCESS: begin
                w_next = RESP;
                gnt0   = r_win == REQ_CPU;
                gnt1   = r_win == REQ_LDR;
                mem_we = r_we && w_in_range;
            end
            RESP: begin
                w_next = IDLE;
                done0  = r_win == REQ_CPU;
                done1  = r_win == REQ_LDR;
                err    = !w_in_range;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= REQ_LDR;
            r_win   <= REQ_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else if (w_start) begin
            r_win   <= w_sel1;
            r_last  <= w_sel1;
            r_we    <= w_sel1 ? we1 : we0;
            r_addr  <= w_sel1 ? addr1 : addr0;
            r_wdata <= w_sel1 ? wdata1 : wdata0;
        end else if (r_state == ACCESS && !r_we) begin
            if (r_win == REQ_CPU) rdata0 <= w_rd;
            else                  rdata1 <= w_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed checks of dmem_arbiter against a
// transaction-level round-robin / memory reference model.
module tb_dmem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 65536;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, err, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_raddr, mem_waddr;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err(err),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // environment memory, bad-address reads return a poison word
    logic [DW-1:0] mem [0:DEPTH-1];
    assign mem_rdata = (mem_raddr < DEPTH) ? mem[mem_raddr[15:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (mem_we && mem_waddr < DEPTH) mem[mem_waddr[15:0]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // reference model state
    logic [DW-1:0] ref_mem [int unsigned];
    int            last;
    logic [DW-1:0] exp_rd [2];
    logic          p [2];
    logic          rwe [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rwd [2];
    int            g_cyc;

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    function automatic logic [DW-1:0] ref_word(input int unsigned a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic drive();
        req0 = p[0]; we0 = rwe[0]; addr0 = raddr[0]; wdata0 = rwd[0];
        req1 = p[1]; we1 = rwe[1]; addr1 = raddr[1]; wdata1 = rwd[1];
    endtask

    task automatic set_req(input int r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p[r] = 1'b1; rwe[r] = w; raddr[r] = a; rwd[r] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        p[0] = 0; p[1] = 0;
        drive();
        #1;
        chk("rst_ctl", {gnt0, gnt1, done0, done1, err, mem_we}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // serves exactly one grant from the currently pending requests; returns in IDLE
    task automatic run_one();
        int w;
        logic [AW-1:0] a;
        logic oob;
        w = (p[0] && p[1]) ? 1 - last : (p[0] ? 0 : 1);
        last = w; a = raddr[w]; oob = a >= DEPTH;
        drive();
        @(posedge clk); #1;
        g_cyc = cyc;
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        chk("mem_we", mem_we, rwe[w] && !oob);
        chk("mem_raddr", mem_raddr, a);
        if (rwe[w]) begin
            chk("mem_waddr", mem_waddr, a);
            chk("mem_wdata", mem_wdata, rwd[w]);
        end
        p[w] = 1'b0;
        drive();
        @(posedge clk); #1;
        if (!rwe[w]) exp_rd[w] = oob ? '0 : ref_word(a);
        else if (!oob) ref_mem[a] = rwd[w];
        chk("done0", done0, w == 0);
        chk("done1", done1, w == 1);
        chk("err", err, oob);
        chk("rdata0", rdata0, exp_rd[0]);
        chk("rdata1", rdata1, exp_rd[1]);
        chk("resp_quiet", {gnt0, gnt1, mem_we}, 0);
        if (!oob) chk("mem_word", mem[a[15:0]], ref_word(a));
        @(posedge clk); #1;
        chk("idle_quiet", {gnt0, gnt1, done0, done1, err, mem_we}, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return AW'(DEPTH - 1 + $urandom_range(0, 2));
        if (k == 1) return AW'($urandom);
        return AW'($urandom_range(0, 15));
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int prev;
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        mem[3] = 23; ref_mem[3] = 23;
        p[0] = 0; p[1] = 0; rwe[0] = 0; rwe[1] = 0;
        raddr[0] = '0; raddr[1] = '0; rwd[0] = '0; rwd[1] = '0;
        do_reset();

        // both readers held high from reset: strict alternation, 3 cycles apart
        set_req(0, 0, 1, 0);
        set_req(1, 0, 2, 0);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            run_one();
            if (i > 0) chk("gnt_gap", g_cyc - prev, 3);
            prev = g_cyc;
            set_req(i % 2, 0, AW'(i % 2 + 1), 0);
        end
        p[0] = 0; p[1] = 0; drive();
        @(posedge clk); #1;

        set_req(0, 1, 5, 32'hAB); run_one();
        set_req(1, 0, 3, 0);      run_one();
        chk("rd_word3", rdata1, 23);
        set_req(0, 1, AW'(DEPTH), 7); run_one();
        chk("word0_kept", mem[0], ref_word(0));

        // reset during ACCESS of a loader write
        set_req(1, 1, 10, 32'h1234_5678);
        drive();
        @(posedge clk); #1;
        chk("pre_rst_gnt1", gnt1, 1);
        chk("pre_rst_we", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {gnt0, gnt1, done0, done1, err, mem_we}, 0);
        chk("mid_rst_rdata", {rdata0, rdata1}, 0);
        last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        chk("word10_kept", mem[10], ref_word(10));
        set_req(0, 0, 4, 0);
        set_req(1, 1, 11, 32'h55);
        drive();
        @(negedge clk);
        rst = 1'b0;
        run_one();
        run_one();

        for (int t = 0; t < 250; t++) begin
            for (int r = 0; r < 2; r++)
                if (!p[r] && $urandom_range(0, 1) == 1)
                    set_req(r, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
            if (p[0] || p[1]) run_one();
            else begin
                drive();
                @(posedge clk); #1;
                chk("no_req_gnt", {gnt0, gnt1, mem_we}, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of both ports and memory.
REQ-002 SHALL have parameter DATA_W, default 32, data width of both ports and memory.
REQ-003 SHALL have parameter MEM_DEPTH, default 65536, number of valid memory words; addresses >= MEM_DEPTH are out of range.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 each, transaction request from requester 0 (CPU) and requester 1 (loader/debug).
REQ-007 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W each, word address.
REQ-009 SHALL have ports wdata0/wdata1, input, DATA_W each, write data.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle grant pulse.
REQ-011 SHALL have ports done0/done1, output, 1 each, one-cycle completion pulse.
REQ-012 SHALL have ports rdata0/rdata1, output, DATA_W each, registered read data.
REQ-013 SHALL have port err, output, 1, one-cycle pulse with done when the address was out of range.
REQ-014 SHALL have ports mem_raddr, mem_waddr, output, ADDR_W each; mem_we, output, 1; mem_wdata, output, DATA_W; mem_rdata, input, DATA_W (combinational memory read).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; IDLE->ACCESS when any req is high; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-016 SHALL, in IDLE, select the winner and latch its we, addr, wdata into internal registers on the transition edge.
REQ-017 SHALL arbitrate round-robin: a lone request wins; on simultaneous req0 and req1, the requester not granted last wins.
REQ-018 SHALL update the last-granted pointer only when a grant is issued; reset value points at requester 1, so requester 0 wins the first tie.
REQ-019 SHALL, in ACCESS, pulse gnt of the winner, drive mem_raddr/mem_waddr/mem_wdata from the latched registers, and assert mem_we only if the latched we = 1 and addr < MEM_DEPTH.
REQ-020 SHALL, in ACCESS, capture mem_rdata into the winner's rdata register for in-range reads, 0 for out-of-range reads; writes leave rdata unchanged.
REQ-021 SHALL, in RESP, pulse done of the winner and pulse err if the latched addr >= MEM_DEPTH.
REQ-022 SHALL give fixed latency: req sampled in IDLE at edge N, gnt high in cycle N+1, done/rdata valid in cycle N+2; next grant no earlier than cycle N+4.
REQ-023 SHALL ignore req changes outside IDLE; requesters hold req, we, addr, wdata until gnt; a req dropped before being sampled is not served.
REQ-024 SHALL hold mem_we low in IDLE and RESP; mem_raddr/mem_waddr hold their last value.
REQ-025 SHALL never assert gnt0 and gnt1, or done0 and done1, in the same cycle.

Reset
REQ-026 SHALL, on rst asserted at any time including mid-transaction, immediately force state IDLE, gnt*/done*/err/mem_we = 0, rdata* = 0, latched registers = 0, pointer = requester 1; an interrupted transaction is dropped with no write performed after reset.
REQ-027 SHALL begin arbitration on the first rising clk edge after rst deasserts.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE=0, ACCESS=1, RESP=2) and requester index constants in shared package dmem_pkg.
REQ-029 SHALL use one sub-module, rr_arb2, as a two-input round-robin arbiter (req, pointer -> one-hot winner); all other logic is flat.

Verification
REQ-030 SHALL cover: req0 write addr=5 wdata=0xAB alone -> gnt0 at N+1 with mem_we=1, mem_waddr=5; done0 at N+2; err=0.
REQ-031 SHALL cover: req1 read addr=3, memory word 3 = 23 -> gnt1 at N+1, done1 at N+2, rdata1=23.
REQ-032 SHALL cover: req0 and req1 reads high continuously from reset -> grants alternate 0,1,0,1 with gnts 3 cycles apart.
REQ-033 SHALL cover: req0 write addr=65536 wdata=7 -> mem_we stays 0, done0 with err=1; word 0 unchanged.
REQ-034 SHALL cover: rst asserted in ACCESS of a req1 write addr=10 -> outputs 0 immediately, word 10 unchanged, req0 served first after release.
